// File: rtl/motor_speed_ctrl.sv
// Motor speed PI controller: four-state update sequence per tick, clamped command output.
// Define MOTOR_CTRL_INTEGRAL_EN to add the integrator; default build is a P-only controller.
module motor_speed_ctrl #(
  parameter int unsigned        KP_SHIFT = 2,
  parameter int unsigned        KI_SHIFT = 5,
  parameter logic signed [15:0] RPM_MAX  = 16'sh157C,
  parameter logic signed [15:0] INT_LIM  = 16'sh2000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               target_valid,
  input  logic signed [15:0] target_rpm,
  input  logic               tick,
  input  logic signed [15:0] rpm_sense,
  output logic signed [15:0] mot_rpm,
  output logic               cmd_valid,
  output logic               busy,
  output logic               sat
);

  localparam int unsigned ERR_W = 17;
  localparam int unsigned U_W   = 18;
  localparam int unsigned ACC_W = 19;

  if (KP_SHIFT > 16 || KI_SHIFT > 16 || INT_LIM <= 0 || RPM_MAX <= 0) begin : g_param_check
    $error("motor_speed_ctrl: invalid parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_CALC   = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [15:0]      r_target;
  logic signed [ERR_W-1:0] r_err;
  logic signed [ERR_W-1:0] r_p;
  logic signed [15:0]      r_mot_rpm;
  logic                    r_sat;
  logic                    r_cmd_valid;
  logic                    r_busy;

  logic signed [U_W-1:0]   w_integ;
  logic signed [U_W-1:0]   w_u;
  logic signed [15:0]      w_cmd;
  logic                    w_clamped;

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Ticks arriving outside IDLE are dropped, not queued.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (tick) w_state_next = S_SAMPLE;
      S_SAMPLE: w_state_next = S_CALC;
      S_CALC:   w_state_next = S_UPDATE;
      S_UPDATE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn)           r_target <= '0;
    else if (target_valid) r_target <= target_rpm;
  end

  // Output clamp to [0, RPM_MAX]; sat records whether clamping occurred.
  always_comb begin
    w_u       = U_W'(r_p) + w_integ;
    w_cmd     = w_u[15:0];
    w_clamped = 1'b0;
    if (w_u < 0) begin
      w_cmd     = '0;
      w_clamped = 1'b1;
    end else if (w_u > U_W'(RPM_MAX)) begin
      w_cmd     = RPM_MAX;
      w_clamped = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err       <= '0;
      r_p         <= '0;
      r_mot_rpm   <= '0;
      r_sat       <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_busy      <= (w_state_next != S_IDLE);
      case (r_state)
        S_SAMPLE: r_err <= ERR_W'(r_target) - ERR_W'(rpm_sense);
        S_CALC:   r_p   <= r_err >>> KP_SHIFT;
        S_UPDATE: begin
          r_mot_rpm   <= w_cmd;
          r_sat       <= w_clamped;
          r_cmd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MOTOR_CTRL_INTEGRAL_EN
  logic signed [U_W-1:0]   r_integ;
  logic signed [ACC_W-1:0] w_integ_sum;
  logic                    w_hold;

  // Anti-windup: freeze while pinned at a rail and the error pushes further into it.
  always_comb begin
    w_integ_sum = ACC_W'(r_integ) + ACC_W'(r_err >>> KI_SHIFT);
    w_hold      = r_sat &&
                  (((r_mot_rpm == RPM_MAX) && !r_err[ERR_W-1] && (r_err != '0)) ||
                   ((r_mot_rpm == '0) && r_err[ERR_W-1]));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_integ <= '0;
    end else if (r_state == S_CALC && !w_hold) begin
      if (w_integ_sum > ACC_W'(INT_LIM))       r_integ <= U_W'(INT_LIM);
      else if (w_integ_sum < -ACC_W'(INT_LIM)) r_integ <= -U_W'(INT_LIM);
      else                                     r_integ <= U_W'(w_integ_sum);
    end
  end

  assign w_integ = r_integ;
`else
  assign w_integ = '0;
`endif

  assign mot_rpm   = r_mot_rpm;
  assign cmd_valid = r_cmd_valid;
  assign busy      = r_busy;
  assign sat       = r_sat;

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Scoreboard bench for motor_speed_ctrl: stimulus pushes expected commands, monitor checks each cmd_valid.
module tb_motor_speed_ctrl;

`ifdef MOTOR_CTRL_INTEGRAL_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               target_valid = 1'b0;
  logic signed [15:0] target_rpm = '0;
  logic               tick = 1'b0;
  logic signed [15:0] rpm_sense = '0;
  logic signed [15:0] mot_rpm;
  logic               cmd_valid;
  logic               busy;
  logic               sat;

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] exp_q[$];

  motor_speed_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .target_valid (target_valid),
    .target_rpm   (target_rpm),
    .tick         (tick),
    .rpm_sense    (rpm_sense),
    .mot_rpm      (mot_rpm),
    .cmd_valid    (cmd_valid),
    .busy         (busy),
    .sat          (sat)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Monitor: every cmd_valid pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (cmd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmd_valid", 1, 0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("mot_rpm", int'(mot_rpm), int'($signed(e[16:1])));
        check("sat", int'(sat), int'(e[0]));
      end
    end
  end

  task automatic do_reset(int cycles);
    @(negedge clk);
    resetn = 1'b0;
    tick = 1'b0;
    target_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_mot_rpm", int'(mot_rpm), 0);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sat", int'(sat), 0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic issue(bit load, int tgt, int sense, int exp_mot, bit exp_sat);
    @(negedge clk);
    target_valid = load;
    target_rpm   = 16'(tgt);
    rpm_sense    = 16'(sense);
    @(negedge clk);
    target_valid = 1'b0;
    tick = 1'b1;
    exp_q.push_back({16'(exp_mot), exp_sat});
    @(posedge clk);
    #1;
    check("busy_after_tick", int'(busy), 1);
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("latency_cmd_valid", int'(cmd_valid), 1);
    check("idle_busy", int'(busy), 0);
  endtask

  initial begin
    do_reset(2);

    issue(1'b1, 4000, 0, INT_EN ? 1125 : 1000, 1'b0);

    do_reset(2);
    issue(1'b1, 5500, -20000, 5500, 1'b1);
    issue(1'b0, 5500, -20000, 5500, 1'b1);
    // Zero error exposes the held integrator directly on the output.
    issue(1'b1, 0, 0, INT_EN ? 796 : 0, 1'b0);

    do_reset(2);
    issue(1'b1, 0, 3000, 0, 1'b1);

    // Back-to-back ticks give one command; a target load during CALC is not used.
    do_reset(2);
    @(negedge clk);
    target_valid = 1'b1;
    target_rpm   = 16'sd400;
    rpm_sense    = 16'sd0;
    @(negedge clk);
    target_valid = 1'b0;
    tick = 1'b1;
    exp_q.push_back({16'(INT_EN ? 112 : 100), 1'b0});
    @(negedge clk);
    @(negedge clk);
    tick = 1'b0;
    target_valid = 1'b1;
    target_rpm   = 16'sd100;
    @(negedge clk);
    target_valid = 1'b0;
    @(posedge clk);
    #1;
    check("double_tick_cmd_valid", int'(cmd_valid), 1);
    repeat (8) @(posedge clk);
    #1;
    check("double_tick_idle", int'(busy), 0);
    issue(1'b0, 0, 0, INT_EN ? 40 : 25, 1'b0);

    issue(1'b1, 4000, 0, INT_EN ? 1140 : 1000, 1'b0);

    // Reset during CALC aborts the update.
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(posedge clk);
    #1;
    check("calc_busy", int'(busy), 1);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_cmd_valid", int'(cmd_valid), 0);
    check("abort_mot_rpm", int'(mot_rpm), 0);
    check("abort_sat", int'(sat), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    issue(1'b1, 0, 0, 0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
